router_nport: RTL and testbench

- Parametrised successor of the 1x3 packet router: one input stream, NUM_PORTS output FIFOs, configurable data width and FIFO depth.
- Integrates header decode, the load FSM, per-port FIFOs, parity and length checking, and soft-reset timeout in one block.
- Adds two behaviours the previous router lacked: packets with an out-of-range address are dropped, and payload length is checked against the header.

---
 rtl/router_nport_if.sv | 25 ++
 rtl/router_nport.sv | 296 +++++++++++++++++++++++++++++
 tb/tb_router_nport.sv | 314 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/router_nport_if.sv
// Stream/port bundle for router_nport: one input packet stream, NUM_PORTS
// read ports, and the busy/err/drop status returned to the sender.
interface router_nport_if #(
  parameter int NUM_PORTS  = 3,
  parameter int DATA_WIDTH = 8
);
  logic [DATA_WIDTH-1:0]           data_in;
  logic                            pkt_valid;
  logic [NUM_PORTS-1:0]            read_enb;
  logic [NUM_PORTS*DATA_WIDTH-1:0] data_out;
  logic [NUM_PORTS-1:0]            vld_out;
  logic                            busy;
  logic                            err;
  logic                            drop;

  modport master (
    output data_in, pkt_valid, read_enb,
    input  data_out, vld_out, busy, err, drop
  );

  modport slave (
    input  data_in, pkt_valid, read_enb,
    output data_out, vld_out, busy, err, drop
  );
endinterface

// File: rtl/router_nport.sv
// router_nport: single input stream routed to NUM_PORTS output FIFOs.
// Header word = {len, addr}; words after the header are payload until the
// cycle with pkt_valid low, which carries the parity word (XOR of header and
// payload). Out-of-range addresses are dropped; parity and length are checked.
// Unread ports are flushed after SOFT_RST_CYCLES stalled cycles.
//
// state      | meaning
// -----------+---------------------------------------------------------------
// DECODE     | idle, waiting for a header word
// WAIT_EMPTY | header latched, target FIFO still holds an older packet
// LOAD_FIRST | write latched header into target FIFO
// LOAD_DATA  | stream payload / parity words into target FIFO
// FULL       | target full, one word parked in the skid register
// LAF        | write the parked skid word once space is back
// CHECK      | compare received parity and payload count against header
// DROP       | discard the remainder of the packet
module router_nport #(
  parameter int NUM_PORTS       = 3,
  parameter int DATA_WIDTH      = 8,
  parameter int FIFO_DEPTH      = 16,
  parameter int SOFT_RST_CYCLES = 30
) (
  input logic           clock,
  input logic           reset,
  router_nport_if.slave bus
);
  localparam int ADDR_W = (NUM_PORTS > 2) ? $clog2(NUM_PORTS) : 1;
  localparam int LEN_W  = DATA_WIDTH - ADDR_W;
  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam int SR_W   = $clog2(SOFT_RST_CYCLES + 1);
  localparam logic [SR_W-1:0] SR_LAST = SR_W'(SOFT_RST_CYCLES - 1);

  typedef enum logic [2:0] {
    DECODE, WAIT_EMPTY, LOAD_FIRST, LOAD_DATA, FULL, LAF, CHECK, DROP
  } state_t;

  state_t state, state_nx;

  logic [DATA_WIDTH-1:0] hdr_q, parity_q, rx_parity_q, skid_q;
  logic                  skid_pv_q;
  logic [ADDR_W-1:0]     target_q;
  logic [LEN_W:0]        count_q;

  logic [NUM_PORTS-1:0]  empty, full, flush, wr_sel;

  logic                  wr_en, wr_payload, wr_parity;
  logic                  hdr_load, par_init, skid_load;
  logic [DATA_WIDTH-1:0] wr_data;
  logic                  busy, err, drop;

  logic                  tgt_empty, tgt_full, tgt_flush, in_empty, in_range;
  logic [ADDR_W-1:0]     in_addr;
  logic [LEN_W-1:0]      len;

  assign in_addr  = bus.data_in[ADDR_W-1:0];
  assign in_range = {1'b0, in_addr} < (ADDR_W+1)'(NUM_PORTS);
  assign len      = hdr_q[DATA_WIDTH-1:ADDR_W];

  assign bus.busy = busy;
  assign bus.err  = err;
  assign bus.drop = drop;

  // Port status as seen from the latched target and from the incoming header.
  always_comb begin
    tgt_empty = 1'b1;
    tgt_full  = 1'b0;
    tgt_flush = 1'b0;
    in_empty  = 1'b1;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (target_q == ADDR_W'(i)) begin
        tgt_empty = empty[i];
        tgt_full  = full[i];
        tgt_flush = flush[i];
      end
      if (in_addr == ADDR_W'(i)) begin
        in_empty = empty[i];
      end
    end
  end

  // FSM state register.
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= DECODE;
    end else begin
      state <= state_nx;
    end
  end

  // FSM next state and per-cycle controls.
  always_comb begin
    state_nx   = state;
    wr_en      = 1'b0;
    wr_data    = bus.data_in;
    wr_payload = 1'b0;
    wr_parity  = 1'b0;
    hdr_load   = 1'b0;
    par_init   = 1'b0;
    skid_load  = 1'b0;
    busy       = 1'b0;
    err        = 1'b0;
    drop       = 1'b0;
    case (state)
      DECODE: begin
        if (bus.pkt_valid) begin
          hdr_load = 1'b1;
          if (!in_range) begin
            state_nx = DROP;
          end else if (in_empty) begin
            state_nx = LOAD_FIRST;
          end else begin
            state_nx = WAIT_EMPTY;
          end
        end
      end
      WAIT_EMPTY: begin
        // A flush of the target simply empties it; the waiting packet has
        // written nothing yet, so it can go ahead.
        busy = 1'b1;
        if (tgt_empty) begin
          state_nx = LOAD_FIRST;
        end
      end
      LOAD_FIRST: begin
        busy = 1'b1;
        if (tgt_flush) begin
          state_nx = DROP;
        end else begin
          wr_en    = 1'b1;
          wr_data  = hdr_q;
          par_init = 1'b1;
          state_nx = LOAD_DATA;
        end
      end
      LOAD_DATA: begin
        if (tgt_flush) begin
          // The word on data_in is consumed this cycle; if it was the
          // parity word the packet is already over.
          if (bus.pkt_valid) begin
            state_nx = DROP;
          end else begin
            drop     = 1'b1;
            state_nx = DECODE;
          end
        end else if (!tgt_full) begin
          wr_en = 1'b1;
          if (bus.pkt_valid) begin
            wr_payload = 1'b1;
          end else begin
            wr_parity = 1'b1;
            state_nx  = CHECK;
          end
        end else begin
          skid_load = 1'b1;
          state_nx  = FULL;
        end
      end
      FULL: begin
        busy = 1'b1;
        if (tgt_flush) begin
          if (skid_pv_q) begin
            state_nx = DROP;
          end else begin
            drop     = 1'b1;
            state_nx = DECODE;
          end
        end else if (!tgt_full) begin
          state_nx = LAF;
        end
      end
      LAF: begin
        busy = 1'b1;
        if (tgt_flush) begin
          if (skid_pv_q) begin
            state_nx = DROP;
          end else begin
            drop     = 1'b1;
            state_nx = DECODE;
          end
        end else begin
          wr_en   = 1'b1;
          wr_data = skid_q;
          if (skid_pv_q) begin
            wr_payload = 1'b1;
            state_nx   = LOAD_DATA;
          end else begin
            wr_parity = 1'b1;
            state_nx  = CHECK;
          end
        end
      end
      CHECK: begin
        busy     = 1'b1;
        err      = (rx_parity_q != parity_q) || (count_q != {1'b0, len});
        state_nx = DECODE;
      end
      DROP: begin
        if (!bus.pkt_valid) begin
          drop     = 1'b1;
          state_nx = DECODE;
        end
      end
      default: begin
        state_nx = DECODE;
      end
    endcase
  end

  // Header latch, running parity, payload count and skid register.
  always_ff @(posedge clock) begin
    if (reset) begin
      hdr_q       <= '0;
      target_q    <= '0;
      parity_q    <= '0;
      rx_parity_q <= '0;
      count_q     <= '0;
      skid_q      <= '0;
      skid_pv_q   <= 1'b0;
    end else begin
      if (hdr_load) begin
        hdr_q    <= bus.data_in;
        target_q <= in_addr;
      end
      if (par_init) begin
        parity_q <= hdr_q;
        count_q  <= '0;
      end
      if (wr_payload) begin
        parity_q <= parity_q ^ wr_data;
        // Saturate so an oversized packet cannot wrap back to a matching length.
        if (!(&count_q)) begin
          count_q <= count_q + (LEN_W+1)'(1);
        end
      end
      if (wr_parity) begin
        rx_parity_q <= wr_data;
      end
      if (skid_load) begin
        skid_q    <= bus.data_in;
        skid_pv_q <= bus.pkt_valid;
      end
    end
  end

  for (genvar g = 0; g < NUM_PORTS; g++) begin : g_port
    logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
    logic [PTR_W:0]        wr_ptr, rd_ptr;
    logic [DATA_WIDTH-1:0] dout;
    logic [SR_W-1:0]       sr_cnt;
    logic                  rd_go;

    assign empty[g]  = (wr_ptr == rd_ptr);
    assign full[g]   = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                       (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);
    assign rd_go     = bus.read_enb[g] && !empty[g];
    assign flush[g]  = !empty[g] && !bus.read_enb[g] && (sr_cnt == SR_LAST);
    assign wr_sel[g] = wr_en && (target_q == ADDR_W'(g)) && !flush[g];

    assign bus.data_out[g*DATA_WIDTH +: DATA_WIDTH] = dout;
    assign bus.vld_out[g] = !empty[g];

    // FIFO storage; no reset needed, pointers define what is valid.
    always_ff @(posedge clock) begin
      if (wr_sel[g]) begin
        mem[wr_ptr[PTR_W-1:0]] <= wr_data;
      end
    end

    // Pointers, registered read port and stalled-reader timer.
    always_ff @(posedge clock) begin
      if (reset) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        dout   <= '0;
        sr_cnt <= '0;
      end else if (flush[g]) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        sr_cnt <= '0;
      end else begin
        if (wr_sel[g]) begin
          wr_ptr <= wr_ptr + (PTR_W+1)'(1);
        end
        if (rd_go) begin
          dout   <= mem[rd_ptr[PTR_W-1:0]];
          rd_ptr <= rd_ptr + (PTR_W+1)'(1);
        end
        if (empty[g] || bus.read_enb[g]) begin
          sr_cnt <= '0;
        end else begin
          sr_cnt <= sr_cnt + SR_W'(1);
        end
      end
    end
  end
endmodule

// File: tb/tb_router_nport.sv
// Bench for router_nport: dut_a uses the default FIFO depth, dut_b a depth
// of 4 for the full/skid path. Both see the same input stream; each test
// follows the busy of the DUT it checks. Expected FIFO words are queued as
// they are sent and popped as they are read back.
module tb_router_nport;
  localparam int NP = 3;
  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic [DW-1:0] din;
  logic          pv;
  logic [NP-1:0] rd_a, rd_b;

  int checks = 0;
  int errors = 0;
  int busy_a = 0, err_a = 0, drop_a = 0;
  int busy_b = 0, err_b = 0, drop_b = 0;

  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] pl[16];

  always #5 clk = ~clk;

  router_nport_if #(.NUM_PORTS(NP), .DATA_WIDTH(DW)) bus_a ();
  router_nport_if #(.NUM_PORTS(NP), .DATA_WIDTH(DW)) bus_b ();

  assign bus_a.data_in   = din;
  assign bus_a.pkt_valid = pv;
  assign bus_a.read_enb  = rd_a;
  assign bus_b.data_in   = din;
  assign bus_b.pkt_valid = pv;
  assign bus_b.read_enb  = rd_b;

  router_nport #(.NUM_PORTS(NP), .DATA_WIDTH(DW), .FIFO_DEPTH(16), .SOFT_RST_CYCLES(30))
    dut_a (.clock(clk), .reset(rst), .bus(bus_a));
  router_nport #(.NUM_PORTS(NP), .DATA_WIDTH(DW), .FIFO_DEPTH(4), .SOFT_RST_CYCLES(30))
    dut_b (.clock(clk), .reset(rst), .bus(bus_b));

  // Pulse / busy-cycle counters, sampled mid-cycle.
  always @(negedge clk) begin
    if (bus_a.busy === 1'b1) busy_a++;
    if (bus_a.err  === 1'b1) err_a++;
    if (bus_a.drop === 1'b1) drop_a++;
    if (bus_b.busy === 1'b1) busy_b++;
    if (bus_b.err  === 1'b1) err_b++;
    if (bus_b.drop === 1'b1) drop_b++;
  end

  function automatic logic busy_of(input int sel);
    return (sel != 0) ? bus_b.busy : bus_a.busy;
  endfunction

  function automatic logic [NP-1:0] vld_of(input int sel);
    return (sel != 0) ? bus_b.vld_out : bus_a.vld_out;
  endfunction

  function automatic logic [DW-1:0] dout_of(input int sel, input int p);
    logic [NP*DW-1:0] v;
    v = (sel != 0) ? bus_b.data_out : bus_a.data_out;
    return v[p*DW +: DW];
  endfunction

  function automatic logic [DW-1:0] calc_par(input logic [DW-1:0] hdr, input int n);
    logic [DW-1:0] p;
    p = hdr;
    for (int k = 0; k < n; k++) p = p ^ pl[k];
    return p;
  endfunction

  task automatic set_rd(input int sel, input int p, input logic v);
    if (sel != 0) rd_b[p] = v;
    else          rd_a[p] = v;
  endtask

  task automatic do_reset();
    rst  = 1'b1;
    din  = '0;
    pv   = 1'b0;
    rd_a = '0;
    rd_b = '0;
    exp_q.delete();
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  // Called at a negedge. Presents header, n payloads, parity; a word is
  // taken at the next rising edge whenever busy is low.
  task automatic send_pkt(input int sel, input logic [DW-1:0] hdr, input int n,
                          input logic [DW-1:0] par, input bit push);
    logic [DW-1:0] w;
    int guard;
    bit stalled;
    stalled = 1'b0;
    for (int k = 0; k < n + 2; k++) begin
      if (k == 0)      w = hdr;
      else if (k <= n) w = pl[k-1];
      else             w = par;
      din = w;
      pv  = (k <= n);
      if (push) exp_q.push_back(w);
      guard = 0;
      while (busy_of(sel) !== 1'b0 && guard < 200) begin
        @(negedge clk);
        guard++;
      end
      if (guard >= 200) stalled = 1'b1;
      @(negedge clk);
    end
    din = '0;
    pv  = 1'b0;
    checks++;
    if (stalled) begin
      errors++;
      $display("FAIL send_stall: busy stayed high, got busy=%b, required 0 within 200 cycles", busy_of(sel));
    end
  endtask

  task automatic drain(input int sel, input int p, input int n, input string tag);
    int guard;
    logic [NP-1:0] v;
    logic [DW-1:0] e;
    for (int k = 0; k < n; k++) begin
      guard = 0;
      v = vld_of(sel);
      while (v[p] !== 1'b1 && guard < 100) begin
        @(negedge clk);
        guard++;
        v = vld_of(sel);
      end
      checks++;
      if (guard >= 100) begin
        errors++;
        $display("FAIL %s_wait word %0d: vld_out=%b, required bit %0d set", tag, k, v, p);
        return;
      end
      set_rd(sel, p, 1'b1);
      @(negedge clk);
      set_rd(sel, p, 1'b0);
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL %s_extra word %0d: got %h, required no word", tag, k, dout_of(sel, p));
      end else begin
        e = exp_q.pop_front();
        if (dout_of(sel, p) !== e) begin
          errors++;
          $display("FAIL %s_data word %0d: got %h, required %h", tag, k, dout_of(sel, p), e);
        end
      end
    end
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (bus_a.vld_out !== 3'b000) begin errors++; $display("FAIL rst_vld: got %b, required 000", bus_a.vld_out); end
    checks++;
    if (bus_a.busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b, required 0", bus_a.busy); end
    checks++;
    if (bus_a.err !== 1'b0 || bus_a.drop !== 1'b0) begin
      errors++; $display("FAIL rst_pulses: got err=%b drop=%b, required 0 0", bus_a.err, bus_a.drop);
    end
    checks++;
    if (bus_a.data_out !== '0) begin errors++; $display("FAIL rst_dout: got %h, required 0", bus_a.data_out); end
    checks++;
    if (bus_b.vld_out !== 3'b000 || bus_b.busy !== 1'b0) begin
      errors++; $display("FAIL rst_b: got vld=%b busy=%b, required 000 0", bus_b.vld_out, bus_b.busy);
    end
  endtask

  task automatic test_mid_reset();
    do_reset();
    din = 8'h0A; pv = 1'b1;          // addr 2, len 2
    @(negedge clk);
    din = 8'h5A;
    @(negedge clk);
    checks++;
    if (bus_a.vld_out !== 3'b100) begin errors++; $display("FAIL mid_pre_vld: got %b, required 100", bus_a.vld_out); end
    rst = 1'b1; pv = 1'b0; din = '0;
    @(negedge clk);
    rst = 1'b0;
    checks++;
    if (bus_a.vld_out !== 3'b000 || bus_a.busy !== 1'b0) begin
      errors++; $display("FAIL mid_post: got vld=%b busy=%b, required 000 0", bus_a.vld_out, bus_a.busy);
    end
  endtask

  task automatic test_basic(input string tag, input logic [DW-1:0] hdr,
                            input logic [DW-1:0] par_flip, input int exp_err);
    int b0, e0;
    do_reset();
    pl[0] = 8'hA1; pl[1] = 8'hB2; pl[2] = 8'hC3; pl[3] = 8'hD4;
    b0 = busy_a; e0 = err_a;
    send_pkt(0, hdr, 4, calc_par(hdr, 4) ^ par_flip, 1'b1);
    repeat (2) @(negedge clk);
    checks++;
    if (err_a - e0 != exp_err) begin
      errors++; $display("FAIL %s_err: got %0d pulses, required %0d", tag, err_a - e0, exp_err);
    end
    checks++;
    if (busy_a - b0 != 2) begin
      errors++; $display("FAIL %s_busy: got %0d busy cycles, required 2", tag, busy_a - b0);
    end
    checks++;
    if (bus_a.vld_out !== 3'b010) begin errors++; $display("FAIL %s_vld: got %b, required 010", tag, bus_a.vld_out); end
    drain(0, 1, 6, tag);
    checks++;
    if (bus_a.vld_out !== 3'b000) begin errors++; $display("FAIL %s_vld_end: got %b, required 000", tag, bus_a.vld_out); end
    checks++;
    if (dout_of(0, 0) !== 8'h00 || dout_of(0, 2) !== 8'h00) begin
      errors++; $display("FAIL %s_other_ports: got %h %h, required 00 00", tag, dout_of(0, 0), dout_of(0, 2));
    end
  endtask

  task automatic test_drop();
    int d0, e0;
    do_reset();
    pl[0] = 8'h01; pl[1] = 8'h02; pl[2] = 8'h03; pl[3] = 8'h04;
    d0 = drop_a; e0 = err_a;
    send_pkt(0, 8'h13, 4, calc_par(8'h13, 4), 1'b0);   // addr 3, len 4
    repeat (2) @(negedge clk);
    checks++;
    if (drop_a - d0 != 1) begin errors++; $display("FAIL drop_pulse: got %0d pulses, required 1", drop_a - d0); end
    checks++;
    if (bus_a.vld_out !== 3'b000) begin errors++; $display("FAIL drop_vld: got %b, required 000", bus_a.vld_out); end
    pl[0] = 8'h77; pl[1] = 8'h88;
    send_pkt(0, 8'h0A, 2, calc_par(8'h0A, 2), 1'b1);   // addr 2, len 2
    repeat (2) @(negedge clk);
    checks++;
    if (bus_a.vld_out !== 3'b100) begin errors++; $display("FAIL drop_next_vld: got %b, required 100", bus_a.vld_out); end
    drain(0, 2, 4, "drop_next");
    checks++;
    if (drop_a - d0 != 1 || err_a - e0 != 0) begin
      errors++; $display("FAIL drop_next_pulses: got drop=%0d err=%0d, required 1 0", drop_a - d0, err_a - e0);
    end
  endtask

  task automatic test_full();
    int d0, e0;
    logic [DW-1:0] par;
    do_reset();
    for (int k = 0; k < 6; k++) pl[k] = 8'(8'h11 * (k + 1));
    par = calc_par(8'h18, 6);                            // addr 0, len 6
    d0 = drop_b; e0 = err_b;
    fork
      send_pkt(1, 8'h18, 6, par, 1'b1);
      begin
        repeat (8) @(negedge clk);
        checks++;
        if (bus_b.busy !== 1'b1 || bus_b.vld_out !== 3'b001) begin
          errors++; $display("FAIL full_hold: got busy=%b vld=%b, required 1 001", bus_b.busy, bus_b.vld_out);
        end
        repeat (5) @(negedge clk);
        drain(1, 0, 8, "full");
      end
    join
    repeat (3) @(negedge clk);
    checks++;
    if (err_b - e0 != 0 || drop_b - d0 != 0) begin
      errors++; $display("FAIL full_pulses: got err=%0d drop=%0d, required 0 0", err_b - e0, drop_b - d0);
    end
    checks++;
    if (bus_b.vld_out !== 3'b000 || exp_q.size() != 0) begin
      errors++; $display("FAIL full_end: got vld=%b pending=%0d, required 000 0", bus_b.vld_out, exp_q.size());
    end
  endtask

  task automatic test_soft_flush();
    int b0, e0, d0;
    do_reset();
    e0 = err_a; d0 = drop_a;
    pl[0] = 8'h3C; pl[1] = 8'hC3;
    send_pkt(0, 8'h08, 2, calc_par(8'h08, 2), 1'b1);   // addr 0, len 2
    exp_q.delete();                                      // this packet gets flushed
    b0 = busy_a;
    pl[0] = 8'h96;
    send_pkt(0, 8'h04, 1, calc_par(8'h04, 1), 1'b1);   // addr 0, len 1
    repeat (2) @(negedge clk);
    checks++;
    if (busy_a - b0 <= 20) begin
      errors++; $display("FAIL flush_wait: got %0d busy cycles, required more than 20", busy_a - b0);
    end
    checks++;
    if (err_a - e0 != 0 || drop_a - d0 != 0) begin
      errors++; $display("FAIL flush_pulses: got err=%0d drop=%0d, required 0 0", err_a - e0, drop_a - d0);
    end
    checks++;
    if (bus_a.vld_out !== 3'b001) begin errors++; $display("FAIL flush_vld: got %b, required 001", bus_a.vld_out); end
    drain(0, 0, 3, "flush");
    checks++;
    if (bus_a.vld_out !== 3'b000) begin errors++; $display("FAIL flush_end: got %b, required 000", bus_a.vld_out); end
  endtask

  initial begin
    rst = 1'b1; din = '0; pv = 1'b0; rd_a = '0; rd_b = '0;
    @(negedge clk);
    test_reset();
    test_mid_reset();
    test_basic("basic", 8'h11, 8'h00, 0);
    test_basic("bad_parity", 8'h11, 8'hFF, 1);
    test_basic("bad_len", 8'h15, 8'h00, 1);
    test_drop();
    test_full();
    test_soft_flush();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1);
  end
endmodule
